// File: rtl/lut_eval_pkg.sv
// lut_eval_pkg: shared types and constants for the lut_eval_seq truth-table evaluator.
package lut_eval_pkg;

    localparam int CFG_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Config beats per table; N_IN >= 3 keeps the table a whole number of bytes.
    function automatic int calc_nb(input int n_in);
        return (1 << n_in) / CFG_W;
    endfunction

endpackage

// File: rtl/lut_eval_cfg.sv
// lut_eval_cfg: byte-stream table loader with shadow/active tables and atomic commit.
module lut_eval_cfg
    import lut_eval_pkg::*;
#(
    parameter int                   N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0] TT_RESET = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_W-1:0]       cfg_data,
    input  logic                   cfg_last,
    output logic                   cfg_err,
    output logic [(1<<N_IN)-1:0]   active_tt,
    output logic                   commit_pulse,
    output cfg_state_e             state_dbg
);

    localparam int TT_W  = 1 << N_IN;
    localparam int NB    = calc_nb(N_IN);
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] beat_idx;
    logic [TT_W-1:0]  shadow_q, shadow_d;
    logic [TT_W-1:0]  active_q, active_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             commit_q, commit_d;
    logic             beat_acc;
    logic             at_final;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = 1'b0;
        beat_acc = cfg_valid && ready_q;
        beat_idx = (state_q == IDLE) ? '0 : cnt_q;
        at_final = (beat_idx == CNT_W'(NB - 1));
        case (state_q)
            IDLE, LOAD: begin
                if (beat_acc) begin
                    shadow_d[beat_idx*CFG_W +: CFG_W] = cfg_data;
                    if (cfg_last && at_final) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else if (cfg_last || at_final) begin
                        // Malformed load: drop the partial shadow, keep the active table.
                        err_d    = 1'b1;
                        shadow_d = active_q;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = beat_idx + 1'b1;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d  = (state_d != COMMIT);
        commit_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= TT_RESET;
            active_q <= TT_RESET;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            commit_q <= commit_d;
        end
    end

    assign cfg_ready    = ready_q;
    assign cfg_err      = err_q;
    assign active_tt    = active_q;
    assign commit_pulse = commit_q;
    assign state_dbg    = state_q;

endmodule

// File: rtl/lut_eval_seq.sv
// lut_eval_seq: N_CH-channel programmable truth-table evaluator with a 2-stage pipeline.
// Define LUT_EVAL_CNT_EN to add the eval_count / load_count statistics ports.
module lut_eval_seq
    import lut_eval_pkg::*;
#(
    parameter int                   N_IN     = 4,
    parameter int                   N_CH     = 1,
    parameter logic [(1<<N_IN)-1:0] TT_RESET = 16'h41A2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_W-1:0]       cfg_data,
    input  logic                   cfg_last,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_CH*N_IN-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH-1:0]        out_data,
    output cfg_state_e             cfg_state
`ifdef LUT_EVAL_CNT_EN
    ,
    output logic [31:0]            eval_count,
    output logic [15:0]            load_count
`endif
);

    localparam int TT_W = 1 << N_IN;

    logic [TT_W-1:0] active_tt;
    logic            commit_pulse;

    lut_eval_cfg #(
        .N_IN     (N_IN),
        .TT_RESET (TT_RESET)
    ) u_cfg (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .cfg_err      (cfg_err),
        .active_tt    (active_tt),
        .commit_pulse (commit_pulse),
        .state_dbg    (cfg_state)
    );

    // Every port pair transfers on a cycle where valid && ready are both high;
    // a source holds valid and data stable until that cycle.
    logic            s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [N_CH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic [N_CH-1:0] lookup;
    logic            s2_ready, s1_adv, in_acc;

    always_comb begin
        lookup = '0;
        for (int c = 0; c < N_CH; c++) begin
            lookup[c] = active_tt[in_data[c*N_IN +: N_IN]];
        end
        s2_ready   = !s2_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_ready;
        in_ready   = !s1_valid_q || s2_ready;
        in_acc     = in_valid && in_ready;
        s1_valid_d = in_acc || (s1_valid_q && !s2_ready);
        s1_data_d  = in_acc ? lookup : s1_data_q;
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s2_data_d  = s1_adv ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

`ifdef LUT_EVAL_CNT_EN
    logic [31:0] eval_count_q, eval_count_d;
    logic [15:0] load_count_q, load_count_d;

    always_comb begin
        eval_count_d = eval_count_q + ((s2_valid_q && out_ready) ? 32'd1 : 32'd0);
        load_count_d = load_count_q + (commit_pulse ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_count_q <= '0;
            load_count_q <= '0;
        end else begin
            eval_count_q <= eval_count_d;
            load_count_q <= load_count_d;
        end
    end

    assign eval_count = eval_count_q;
    assign load_count = load_count_q;
`else
    logic unused_commit;
    assign unused_commit = commit_pulse;
`endif

endmodule
